// File: rtl/acc_11bit_pkg.sv
// Shared defaults and state encoding for the frame accumulator.
package acc_11bit_pkg;

    localparam int ACC_WIDTH = 11;
    localparam int ACC_CNT_W = 8;

    typedef logic [0:0] state_t;

    localparam state_t ST_ACC = 1'b0;
    localparam state_t ST_OUT = 1'b1;

endpackage

// File: rtl/csa_11bit.sv
// 11-bit carry-select adder: 5-bit ripple low half, upper 6 bits precomputed
// for both carry-ins and selected by the low-half carry.
module csa_11bit (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [10:0] sum,
    output logic        cout
);

    logic [4:0] lo;
    logic       lo_c;
    logic [5:0] hi0;
    logic [5:0] hi1;
    logic       hi0_c;
    logic       hi1_c;

    assign {lo_c, lo}    = {1'b0, a[4:0]} + {1'b0, b[4:0]};
    assign {hi0_c, hi0}  = {1'b0, a[10:5]} + {1'b0, b[10:5]};
    assign {hi1_c, hi1}  = {1'b0, a[10:5]} + {1'b0, b[10:5]} + 7'd1;

    assign sum  = {lo_c ? hi1 : hi0, lo};
    assign cout = lo_c ? hi1_c : hi0_c;

endmodule

// File: rtl/acc_11bit.sv
// Frame accumulator: sums operands until i_last, then presents sum, sticky
// carry-out and saturating operand count until the downstream handshake.
module acc_11bit
    import acc_11bit_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    csa_11bit u_csa (
        .a    (acc_q),
        .b    (i_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept = i_valid && (state_q == ST_ACC);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (state_q == ST_ACC) begin
            if (accept) begin
                acc_d = add_sum;
                ovf_d = ovf_q | add_cout;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (i_last) begin
                    state_d = ST_OUT;
                end
            end
        end else if (i_ready) begin
            // Result consumed: clear for the next frame.
            state_d = ST_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign o_ready = (state_q == ST_ACC);
    assign o_valid = (state_q == ST_OUT);
    assign o_sum   = acc_q;
    assign o_ovf   = ovf_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_acc_11bit.sv
// Self-checking bench for acc_11bit: directed frame table, reset corner cases
// and random frames checked against an arithmetic reference model.
module tb_acc_11bit;

    localparam int WIDTH = 11;
    localparam int CNT_W = 8;
    localparam longint MODV = 2048;
    localparam longint CMAX = 255;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_ovf;
    logic [CNT_W-1:0] o_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] ops[$];

    typedef struct {
        string           name;
        int              n;
        logic [3:0][10:0] v;
        longint          sum;
        longint          cnt;
        longint          ovf;
    } vec_t;

    vec_t tbl[5];

    always #5 i_clk = ~i_clk;

    acc_11bit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf),
        .o_count (o_count)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] d, input logic last);
        check("ready_before_accept", o_ready, 1);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        step();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Drives ops[] as one frame, checks result against the model (or against
    // the given constants when use_exp is set), holds, then handshakes.
    task automatic feed_frame(input int gap_max, input int hold, input bit use_exp,
                              input longint e_sum, input longint e_cnt, input longint e_ovf);
        longint total = 0;
        longint n = 0;
        longint m_sum, m_cnt, m_ovf;
        foreach (ops[k]) begin
            int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) step();
            accept(ops[k], k == ops.size() - 1);
            total += longint'(ops[k]);
            n++;
            if (k != ops.size() - 1) begin
                check("run_sum", o_sum, total % MODV);
                check("run_cnt", o_count, (n > CMAX) ? CMAX : n);
                check("run_valid", o_valid, 0);
            end
        end
        m_sum = use_exp ? e_sum : total % MODV;
        m_cnt = use_exp ? e_cnt : ((n > CMAX) ? CMAX : n);
        m_ovf = use_exp ? e_ovf : ((total >= MODV) ? 1 : 0);
        check("res_valid", o_valid, 1);
        check("res_ready", o_ready, 0);
        check("res_sum", o_sum, m_sum);
        check("res_cnt", o_count, m_cnt);
        check("res_ovf", o_ovf, m_ovf);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = WIDTH'($urandom);
            i_last  = 1'($urandom_range(0, 1));
            step();
            check("hold_valid", o_valid, 1);
            check("hold_ready", o_ready, 0);
            check("hold_sum", o_sum, m_sum);
            check("hold_cnt", o_count, m_cnt);
            check("hold_ovf", o_ovf, m_ovf);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("post_valid", o_valid, 0);
        check("post_ready", o_ready, 1);
        check("post_sum", o_sum, 0);
        check("post_cnt", o_count, 0);
        check("post_ovf", o_ovf, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_ready"}, o_ready, 1);
        check({tag, "_sum"}, o_sum, 0);
        check({tag, "_cnt"}, o_count, 0);
        check({tag, "_ovf"}, o_ovf, 0);
    endtask

    initial begin
        tbl[0] = '{"sum600",  3, {11'd0, 11'd300, 11'd200, 11'd100}, 600, 3, 0};
        tbl[1] = '{"wrap",    2, {11'd0, 11'd0, 11'd1, 11'd2047}, 0, 2, 1};
        tbl[2] = '{"single",  1, {11'd0, 11'd0, 11'd0, 11'h5A5}, 'h5A5, 1, 0};
        tbl[3] = '{"four_max", 4, {11'd2047, 11'd2047, 11'd2047, 11'd2047}, 2044, 4, 1};
        tbl[4] = '{"zeros",   2, {11'd0, 11'd0, 11'd0, 11'd0}, 0, 2, 0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        check_idle("reset");

        // Directed table; first entry also exercises a 5-cycle hold.
        for (int t = 0; t < 5; t++) begin
            ops.delete();
            for (int j = 0; j < tbl[t].n; j++) ops.push_back(tbl[t].v[j]);
            feed_frame(0, (t == 0) ? 5 : 1, 1'b1, tbl[t].sum, tbl[t].cnt, tbl[t].ovf);
        end

        // Reset mid-frame, colliding with a valid operand.
        accept(11'd40, 1'b0);
        accept(11'd50, 1'b0);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_data  = 11'd500;
        step();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        check_idle("abort");
        repeat (2) step();
        check("abort_no_result", o_valid, 0);
        ops.delete();
        ops.push_back(11'd7);
        ops.push_back(11'd8);
        feed_frame(0, 0, 1'b1, 15, 2, 0);

        // Reset while a result is pending.
        accept(11'd9, 1'b1);
        check("out_pending", o_valid, 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_idle("rst_out");
        step();
        check("rst_out_stay", o_valid, 0);

        // Count saturation.
        ops.delete();
        for (int j = 0; j < 300; j++) ops.push_back(11'd1);
        feed_frame(0, 0, 1'b1, 300, 255, 0);

        // Random frames against the arithmetic model.
        for (int f = 0; f < 30; f++) begin
            int len = $urandom_range(1, 40);
            ops.delete();
            for (int j = 0; j < len; j++) ops.push_back(WIDTH'($urandom_range(0, 2047)));
            feed_frame(2, $urandom_range(0, 3), 1'b0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
